xsr_ctl: RTL

Register-mapped controller that configures, sequences and drains one `xsr` serial receiver. It holds the receiver in reset while disabled and drives its frame-length and baud settings. It detects frame completion, gates the receiver's shift register onto its data bus for one cycle, right-aligns the frame and pushes it into a small receive FIFO. A host reads status and pops frames through a four-register bus port.

---
 rtl/xsr_ctl_pkg.sv | 32 +++
 rtl/xsr_fifo.sv | 49 ++++
 rtl/xsr_ctl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/xsr_ctl_pkg.sv
// Shared definitions for the xsr receiver controller: register map, bit positions, FSM states.
// Also holds the frame alignment helper used on capture.
package xsr_ctl_pkg;

   localparam logic [1:0] ADR_CTRL   = 2'd0;
   localparam logic [1:0] ADR_BAUD   = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;
   localparam logic [1:0] ADR_DATA   = 2'd3;

   localparam int CTRL_EN      = 8;
   localparam int CTRL_IRQ_EN  = 9;

   localparam int STAT_NE      = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVR     = 2;
   localparam int STAT_BUSY    = 3;
   localparam int STAT_CNT_LSB = 8;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_BUSY = 2'd1,
      S_CAPT = 2'd2
   } state_t;

   // The receiver shifts in from the top, so a frame of 'bits' sits left-aligned.
   function automatic logic [63:0] align_frame(input logic [63:0] sr, input logic [5:0] bits);
      logic [6:0] sh;
      sh = 7'd64 - {1'b0, bits};
      return sr >> sh;
   endfunction

endpackage

// File: rtl/xsr_fifo.sv
// Synchronous FIFO, head visible combinationally; one cycle from push to visibility.
// Push while full is accepted only when a pop happens the same cycle; otherwise it is dropped.
module xsr_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             pop_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_dat = mem[rp];
   assign count   = cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wp] <= push_dat;
   end

endmodule

// File: rtl/xsr_ctl.sv
// Register-mapped controller for one xsr receiver: config, capture FSM, receive FIFO, host port.
// Bus access acks one cycle after the strobe; frames reach the FIFO two cycles after rx idle rises.
module xsr_ctl
   import xsr_ctl_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [63:0] BAUD_RST = 64'd16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [1:0]  adr_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [63:0] dat_i,
   output logic [63:0] dat_o,
   output logic        ack_o,
   output logic        irq_o,
   output logic        xsr_reset_o,
   output logic [5:0]  bits_o,
   output logic [63:0] baud_o,
   output logic        rxreg_oe_o,
   input  logic [63:0] rx_dat_i,
   input  logic        rx_idle_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t        state_q, state_d;
   logic [5:0]    bits_q;
   logic          en_q, irq_en_q, cfg_wr_q, ovr_q, ack_q, irq_q;
   logic [63:0]   baud_q, dat_q;
   logic          wr, rd, run, push, pop, full, empty;
   logic [CW-1:0] count;
   logic [63:0]   head, frame, status, rd_val;

   assign wr    = stb_i & we_i;
   assign rd    = stb_i & ~we_i;
   assign run   = en_q & (bits_q != 6'd0);
   assign pop   = rd & (adr_i == ADR_DATA) & ~empty;
   assign push  = (state_q == S_CAPT);
   assign frame = align_frame(rx_dat_i, bits_q);

   // A config write holds the receiver in reset for one cycle so it restarts cleanly.
   assign xsr_reset_o = ~run | reset_i | cfg_wr_q;
   assign bits_o      = bits_q;
   assign baud_o      = baud_q;
   assign ack_o       = ack_q;
   assign dat_o       = dat_q;
   assign irq_o       = irq_q;

   xsr_fifo #(.W(64), .DEPTH(DEPTH)) u_fifo (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .push     (push),
      .push_dat (frame),
      .pop      (pop),
      .pop_dat  (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      status                              = '0;
      status[STAT_NE]                     = ~empty;
      status[STAT_FULL]                   = full;
      status[STAT_OVR]                    = ovr_q;
      status[STAT_BUSY]                   = (state_q == S_BUSY);
      status[STAT_CNT_LSB+7:STAT_CNT_LSB] = 8'(count);
   end

   always_comb begin
      rd_val = '0;
      unique case (adr_i)
         ADR_CTRL:   rd_val = {54'd0, irq_en_q, en_q, 2'd0, bits_q};
         ADR_BAUD:   rd_val = baud_q;
         ADR_STATUS: rd_val = status;
         ADR_DATA:   rd_val = empty ? 64'd0 : head;
         default:    rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         bits_q   <= '0;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         baud_q   <= BAUD_RST;
         cfg_wr_q <= 1'b0;
         ovr_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         ack_q    <= stb_i;
         dat_q    <= rd ? rd_val : 64'd0;
         cfg_wr_q <= wr & ((adr_i == ADR_CTRL) | (adr_i == ADR_BAUD));
         if (wr && adr_i == ADR_CTRL) begin
            bits_q   <= dat_i[5:0];
            en_q     <= dat_i[CTRL_EN];
            irq_en_q <= dat_i[CTRL_IRQ_EN];
         end
         if (wr && adr_i == ADR_BAUD) baud_q <= dat_i;
         ovr_q <= (ovr_q & ~(wr & (adr_i == ADR_STATUS) & dat_i[STAT_OVR]))
                | (push & full & ~pop);
         irq_q <= irq_en_q & (~empty | ovr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_WAIT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT: if (run && !rx_idle_i) state_d = S_BUSY;
         S_BUSY: begin
            // Abort wins over completion: a reset receiver reports idle with garbage.
            if (xsr_reset_o)    state_d = S_WAIT;
            else if (rx_idle_i) state_d = S_CAPT;
         end
         S_CAPT:  state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      rxreg_oe_o = (state_q == S_CAPT);
   end

endmodule
